// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions for the RISC-V core: per-stage bundle layouts,
// their widths, and the control enums carried in the bundles.
package riscv_pipe_pkg;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2,
        RES_IMM = 2'd3
    } result_src_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_ctrl_e;

    typedef struct packed {
        logic        reg_write;
        result_src_e result_src;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic        alu_src;
        logic        pc_target_src;
    } id_ex_ctrl_t;

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] imm_ext;
        logic [31:0] pc_plus4;
        logic [4:0]  rd;
    } id_ex_data_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } if_id_data_t;

    localparam int unsigned IF_ID_CTRL_W = 1;
    localparam int unsigned IF_ID_DATA_W = $bits(if_id_data_t);
    localparam int unsigned ID_EX_CTRL_W = $bits(id_ex_ctrl_t);
    localparam int unsigned ID_EX_DATA_W = $bits(id_ex_data_t);
    localparam int unsigned BUBBLE_CNT_W = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear, shared by the stage performance monitors.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q, cnt_d;

    // next count: clear wins, otherwise increment until all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign q = cnt_q;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Elastic inter-stage pipeline register: valid/ready handshake, flush-to-bubble,
// optional 2-entry skid buffer with registered in_ready, saturating bubble counter.
module pipe_stage_skid_reg
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned CTRL_W     = ID_EX_CTRL_W,
    parameter int unsigned DATA_W     = ID_EX_DATA_W,
    parameter bit          SKID       = 1'b1,
    parameter bit          CLEAR_DATA = 1'b0,
    parameter int unsigned CNT_W      = BUBBLE_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    logic              push_s, pop_s, bubble_s;
    logic              main_vld_q, main_vld_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [DATA_W-1:0] main_data_flush_s;

    assign push_s   = in_valid & in_ready;
    assign pop_s    = main_vld_q & out_ready;
    assign bubble_s = out_ready & ~main_vld_q;

    if (CLEAR_DATA) begin : gen_clear_data
        assign main_data_flush_s = '0;
    end else begin : gen_keep_data
        assign main_data_flush_s = main_data_q;
    end

    if (SKID) begin : gen_skid
        state_e            state_q, state_d;
        logic              in_ready_q;
        logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
        logic [DATA_W-1:0] skid_data_q, skid_data_d;

        // next state and entry loads; ctrl of an emptied entry is zeroed so bubbles carry no writes
        always_comb begin
            state_d     = state_q;
            main_vld_d  = main_vld_q;
            main_ctrl_d = main_ctrl_q;
            main_data_d = main_data_q;
            skid_ctrl_d = skid_ctrl_q;
            skid_data_d = skid_data_q;
            if (flush) begin
                state_d     = EMPTY;
                main_vld_d  = 1'b0;
                main_ctrl_d = '0;
                main_data_d = main_data_flush_s;
                skid_ctrl_d = '0;
                skid_data_d = CLEAR_DATA ? '0 : skid_data_q;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (push_s) begin
                            state_d     = ONE;
                            main_vld_d  = 1'b1;
                            main_ctrl_d = in_ctrl;
                            main_data_d = in_data;
                        end else begin
                            state_d = EMPTY;
                        end
                    end
                    ONE: begin
                        if (push_s && !pop_s) begin
                            state_d     = FULL;
                            skid_ctrl_d = in_ctrl;
                            skid_data_d = in_data;
                        end else if (pop_s && !push_s) begin
                            state_d     = EMPTY;
                            main_vld_d  = 1'b0;
                            main_ctrl_d = '0;
                        end else if (push_s && pop_s) begin
                            main_ctrl_d = in_ctrl;
                            main_data_d = in_data;
                        end else begin
                            state_d = ONE;
                        end
                    end
                    FULL: begin
                        if (pop_s) begin
                            state_d     = ONE;
                            main_ctrl_d = skid_ctrl_q;
                            main_data_d = skid_data_q;
                            skid_ctrl_d = '0;
                        end else begin
                            state_d = FULL;
                        end
                    end
                    default: begin
                        state_d     = EMPTY;
                        main_vld_d  = 1'b0;
                        main_ctrl_d = '0;
                        skid_ctrl_d = '0;
                    end
                endcase
            end
        end

        // state, skid entry and in_ready flop (no path from out_ready to in_ready)
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q     <= EMPTY;
                in_ready_q  <= 1'b1;
                skid_ctrl_q <= '0;
                skid_data_q <= '0;
            end else begin
                state_q     <= state_d;
                in_ready_q  <= (state_d != FULL);
                skid_ctrl_q <= skid_ctrl_d;
                skid_data_q <= skid_data_d;
            end
        end

        assign in_ready = in_ready_q;
    end else begin : gen_single
        // single entry: a push may reload the head in the same cycle it is popped
        always_comb begin
            main_vld_d  = main_vld_q;
            main_ctrl_d = main_ctrl_q;
            main_data_d = main_data_q;
            if (flush) begin
                main_vld_d  = 1'b0;
                main_ctrl_d = '0;
                main_data_d = main_data_flush_s;
            end else if (push_s) begin
                main_vld_d  = 1'b1;
                main_ctrl_d = in_ctrl;
                main_data_d = in_data;
            end else if (pop_s) begin
                main_vld_d  = 1'b0;
                main_ctrl_d = '0;
            end else begin
                main_vld_d = main_vld_q;
            end
        end

        assign in_ready = ~main_vld_q | out_ready;
    end

    // head entry register
    always_ff @(posedge clk) begin
        if (rst) begin
            main_vld_q  <= 1'b0;
            main_ctrl_q <= '0;
            main_data_q <= '0;
        end else begin
            main_vld_q  <= main_vld_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
        end
    end

    assign out_valid = main_vld_q;
    assign out_ctrl  = main_ctrl_q;
    assign out_data  = main_data_q;

    sat_counter #(
        .W(CNT_W)
    ) u_bubble_cnt (
        .clk(clk),
        .inc(bubble_s),
        .clr(rst),
        .q  (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Directed vector bench: skid instance driven from a cycle table, single-entry
// instance exercised by hand sequences and a random scoreboard run.
module tb_pipe_stage_skid_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // instance A: SKID=1, CLEAR_DATA=0, full-width bundles, 32-bit counter
    logic         rst_a, flush_a, iv_a, ir_a, ov_a, ordy_a;
    logic [7:0]   ic_a, oc_a;
    logic [164:0] id_a, od_a;
    logic [31:0]  bc_a;

    // instance B: SKID=0, CLEAR_DATA=1, narrow data, 4-bit counter
    logic         rst_b, flush_b, iv_b, ir_b, ov_b, ordy_b;
    logic [7:0]   ic_b, oc_b;
    logic [15:0]  id_b, od_b;
    logic [3:0]   bc_b;

    pipe_stage_skid_reg #(
        .CTRL_W(8), .DATA_W(165), .SKID(1'b1), .CLEAR_DATA(1'b0), .CNT_W(32)
    ) u_a (
        .clk(clk), .rst(rst_a), .flush(flush_a), .in_valid(iv_a), .in_ready(ir_a),
        .in_ctrl(ic_a), .in_data(id_a), .out_valid(ov_a), .out_ready(ordy_a),
        .out_ctrl(oc_a), .out_data(od_a), .bubble_cnt(bc_a)
    );

    pipe_stage_skid_reg #(
        .CTRL_W(8), .DATA_W(16), .SKID(1'b0), .CLEAR_DATA(1'b1), .CNT_W(4)
    ) u_b (
        .clk(clk), .rst(rst_b), .flush(flush_b), .in_valid(iv_b), .in_ready(ir_b),
        .in_ctrl(ic_b), .in_data(id_b), .out_valid(ov_b), .out_ready(ordy_b),
        .out_ctrl(oc_b), .out_data(od_b), .bubble_cnt(bc_b)
    );

    typedef struct {
        logic        rst;
        logic        flush;
        logic        iv;
        logic        ordy;
        logic [7:0]  ictrl;
        logic        chk;
        logic        e_ir;
        logic        e_ov;
        logic [7:0]  e_oc;
        logic [7:0]  e_od;
        logic [31:0] e_bc;
    } vec_t;

    vec_t vecs[30];

    typedef struct {
        logic [7:0]  c;
        logic [15:0] d;
    } ent_t;

    ent_t sb[$];

    function automatic logic [164:0] mk_data(input logic [7:0] c);
        return {c, 149'd0, c};
    endfunction

    task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        rst_a = 1'b1; flush_a = 1'b0; iv_a = 1'b0; ordy_a = 1'b0; ic_a = 8'h00; id_a = '0;
        rst_b = 1'b1; flush_b = 1'b0; iv_b = 1'b1; ordy_b = 1'b0; ic_b = 8'h00; id_b = 16'h0000;

        // rst, flush, iv, ordy, ictrl, chk, e_ir, e_ov, e_oc, e_od, e_bc
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 32'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h77, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 32'd0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 32'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 32'd0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h02, 1'b1, 1'b1, 1'b1, 8'h01, 8'h01, 32'd0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h03, 1'b1, 1'b0, 1'b1, 8'h01, 8'h01, 32'd0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 8'h01, 8'h01, 32'd0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 8'h02, 8'h02, 32'd0};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 8'h03, 8'h03, 32'd0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 8'h04, 8'h04, 32'd0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h05, 8'h05, 32'd0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b1, 1'b1, 8'h05, 8'h05, 32'd0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hAA, 8'hAA, 32'd0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'hBB, 1'b1, 1'b1, 1'b1, 8'hAA, 8'hAA, 32'd0};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'hCC, 1'b1, 1'b0, 1'b1, 8'hAA, 8'hAA, 32'd0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'hAA, 32'd0};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'hDD, 1'b1, 1'b1, 1'b0, 8'h00, 8'hAA, 32'd0};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 8'hDD, 8'hDD, 32'd0};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'hDD, 32'd0};
        for (int i = 19; i < 29; i++) begin
            vecs[i] = '{1'b0, (i == 22), 1'b1 ^ 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'hDD, 32'(i - 19)};
        end
        vecs[29] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'hDD, 32'd10};

        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            rst_a   = vecs[i].rst;
            flush_a = vecs[i].flush;
            iv_a    = vecs[i].iv;
            ordy_a  = vecs[i].ordy;
            ic_a    = vecs[i].ictrl;
            id_a    = mk_data(vecs[i].ictrl);
            #1;
            if (vecs[i].chk) begin
                check($sformatf("a_v%0d_in_ready", i), 200'(ir_a), 200'(vecs[i].e_ir));
                check($sformatf("a_v%0d_out_valid", i), 200'(ov_a), 200'(vecs[i].e_ov));
                check($sformatf("a_v%0d_out_ctrl", i), 200'(oc_a), 200'(vecs[i].e_oc));
                check($sformatf("a_v%0d_out_data", i), 200'(od_a), 200'(mk_data(vecs[i].e_od)));
                check($sformatf("a_v%0d_bubble_cnt", i), 200'(bc_a), 200'(vecs[i].e_bc));
            end
        end

        // instance B: reset state while in_valid is high
        @(negedge clk);
        #1;
        check("b_rst_out_valid", 200'(ov_b), 200'(1'b0));
        check("b_rst_out_ctrl", 200'(oc_b), 200'(8'h00));
        check("b_rst_out_data", 200'(od_b), 200'(16'h0000));
        check("b_rst_bubble_cnt", 200'(bc_b), 200'(4'd0));

        // bubble counter: 10 cycles then saturation at 15 after 20
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rst_b = 1'b0; iv_b = 1'b0; ordy_b = 1'b1;
            #1;
            if (i == 0) check("b_in_ready_after_rst", 200'(ir_b), 200'(1'b1));
            if (i == 10) check("b_bubble_10", 200'(bc_b), 200'(4'd10));
        end
        @(negedge clk);
        ordy_b = 1'b0;
        #1;
        check("b_bubble_sat", 200'(bc_b), 200'(4'd15));

        // flush with CLEAR_DATA=1 zeroes data; push during flush is discarded
        iv_b = 1'b1; ic_b = 8'h3C; id_b = 16'h1234;
        #1;
        check("b_push_ready", 200'(ir_b), 200'(1'b1));
        @(negedge clk);
        iv_b = 1'b0;
        #1;
        check("b_head_ctrl", 200'(oc_b), 200'(8'h3C));
        check("b_head_data", 200'(od_b), 200'(16'h1234));
        flush_b = 1'b1; iv_b = 1'b1; ordy_b = 1'b1; ic_b = 8'h55; id_b = 16'h5555;
        @(negedge clk);
        flush_b = 1'b0; iv_b = 1'b0; ordy_b = 1'b0;
        #1;
        check("b_flush_valid", 200'(ov_b), 200'(1'b0));
        check("b_flush_ctrl", 200'(oc_b), 200'(8'h00));
        check("b_flush_data", 200'(od_b), 200'(16'h0000));

        // random handshake against a scoreboard queue
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            iv_b   = 1'($urandom_range(0, 1));
            ordy_b = 1'($urandom_range(0, 1));
            ic_b   = 8'($urandom);
            id_b   = 16'($urandom);
            #1;
            check("r_in_ready", 200'(ir_b), 200'(!ov_b || ordy_b));
            check("r_out_valid", 200'(ov_b), 200'(sb.size() != 0));
            if (ov_b && ordy_b && sb.size() != 0) begin
                check("r_pop_ctrl", 200'(oc_b), 200'(sb[0].c));
                check("r_pop_data", 200'(od_b), 200'(sb[0].d));
                void'(sb.pop_front());
            end else if (!ov_b) begin
                check("r_bubble_ctrl", 200'(oc_b), 200'(8'h00));
            end
            if (iv_b && ir_b) begin
                sb.push_back('{ic_b, id_b});
            end
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
